// File: rtl/rom_read_arbiter.sv
// Two-port round-robin read arbiter and burst sequencer for a combinational lookup ROM.
// Optional out-of-range beat flagging is enabled by defining ROM_ARB_RANGE_CHECK_EN.
module rom_read_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4,
  parameter int ROM_DEPTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [LEN_WIDTH-1:0]  req0_len,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [LEN_WIDTH-1:0]  req1_len,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp0_last,
  output logic                  rsp0_err,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rsp1_last,
  output logic                  rsp1_err,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  output logic                  busy
);

`ifdef ROM_ARB_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = ROM_DEPTH[ADDR_WIDTH:0];

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                state;
  state_t                state_next;
  logic                  last_grant;
  logic                  owner;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  rsp_valid_int;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_last;
  logic                  rsp_err;

  logic grant_any;
  logic grant_port;
  logic owner_ready;
  logic handshake;
  logic load;
  logic beat_oor;
  logic beat_err;

  // On a tie the port that did not win last time is served.
  assign grant_any   = req0_valid | req1_valid;
  assign grant_port  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  assign owner_ready = owner ? rsp1_ready : rsp0_ready;
  assign handshake   = rsp_valid_int & owner_ready;
  assign load        = (state == STREAM) && (!rsp_valid_int || owner_ready);
  assign beat_oor    = ({1'b0, cur_addr} >= DEPTH_LIM);
  assign beat_err    = RANGE_CHECK && beat_oor;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = STREAM;
      STREAM:  if (load && (remaining == '0)) state_next = DRAIN;
      DRAIN:   if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = (state != IDLE);
    if ((state == IDLE) && grant_any) begin
      req0_ready = ~grant_port;
      req1_ready = grant_port;
    end
  end

  // A new beat loads whenever the output register is empty or being consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      cur_addr      <= '0;
      remaining     <= '0;
      rsp_valid_int <= 1'b0;
      rsp_data      <= '0;
      rsp_last      <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      if ((state == IDLE) && grant_any) begin
        last_grant <= grant_port;
        owner      <= grant_port;
        cur_addr   <= grant_port ? req1_addr : req0_addr;
        remaining  <= grant_port ? req1_len : req0_len;
      end
      if (load) begin
        rsp_valid_int <= 1'b1;
        rsp_data      <= beat_err ? '0 : rom_dout;
        rsp_last      <= (remaining == '0);
        rsp_err       <= beat_err;
        cur_addr      <= cur_addr + 1'b1;
        remaining     <= remaining - 1'b1;
      end else if ((state == DRAIN) && handshake) begin
        rsp_valid_int <= 1'b0;
      end
    end
  end

  assign rom_addr   = cur_addr;
  assign rsp0_valid = rsp_valid_int & ~owner;
  assign rsp1_valid = rsp_valid_int & owner;
  assign rsp0_data  = rsp_data;
  assign rsp1_data  = rsp_data;
  assign rsp0_last  = rsp_last;
  assign rsp1_last  = rsp_last;
  assign rsp0_err   = rsp_err;
  assign rsp1_err   = rsp_err;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter: expected beats are queued per port at request time
// and popped as each response handshake is observed. Honors ROM_ARB_RANGE_CHECK_EN.
module tb_rom_read_arbiter;

`ifdef ROM_ARB_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       err;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_addr = 4'd0, req1_addr = 4'd0;
  logic [3:0] req0_len = 4'd0, req1_len = 4'd0;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [7:0] rsp0_data, rsp1_data;
  logic       rsp0_last, rsp1_last, rsp0_err, rsp1_err;
  logic [3:0] rom_addr;
  logic [7:0] rom_dout;
  logic       busy;

  int    total = 0;
  int    bad = 0;
  beat_t q0[$];
  beat_t q1[$];
  int    grant_log[$];
  bit    stall_prev = 1'b0;
  bit    stall_port = 1'b0;
  beat_t stall_beat;

  rom_read_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_len(req0_len),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_len(req1_len),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_last(rsp0_last), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_last(rsp1_last), .rsp1_err(rsp1_err),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] romModel(input logic [3:0] a);
    case (a)
      4'd0:    romModel = 8'hA1;
      4'd1:    romModel = 8'hB2;
      4'd2:    romModel = 8'hC3;
      4'd3:    romModel = 8'hD4;
      4'd4:    romModel = 8'hE5;
      4'd5:    romModel = 8'hF6;
      default: romModel = {4'h9, a};
    endcase
  endfunction

  assign rom_dout = romModel(rom_addr);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pushExpected(input int port, input logic [3:0] addr, input logic [3:0] len);
    beat_t      b;
    logic [3:0] a;
    for (int i = 0; i <= int'(len); i++) begin
      a      = addr + 4'(i);
      b.err  = RANGE_EN && (a >= 4'd6);
      b.data = b.err ? 8'h00 : romModel(a);
      b.last = (i == int'(len));
      if (port == 0) q0.push_back(b);
      else q1.push_back(b);
    end
  endtask

  // Raises a request, waits for its grant, then drops valid one cycle later.
  task automatic applyStimulus(input int port, input logic [3:0] addr, input logic [3:0] len,
                               output int waited);
    bit granted = 1'b0;
    waited = 0;
    pushExpected(port, addr, len);
    if (port == 0) begin
      req0_addr = addr; req0_len = len; req0_valid = 1'b1;
    end else begin
      req1_addr = addr; req1_len = len; req1_valid = 1'b1;
    end
    while (!granted && waited < 200) begin
      @(negedge clk);
      granted = (port == 0) ? req0_ready : req1_ready;
      waited++;
    end
    checkOutput("grant_seen", 32'(granted), 1);
    grant_log.push_back(port);
    @(posedge clk);
    #1;
    if (port == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic scoreBeat(input int port, input beat_t got);
    beat_t e;
    int    n;
    n = (port == 0) ? q0.size() : q1.size();
    checkOutput("beat_expected", 32'(n != 0), 1);
    if (n != 0) begin
      if (port == 0) e = q0.pop_front();
      else e = q1.pop_front();
      checkOutput("beat_data", 32'(got.data), 32'(e.data));
      checkOutput("beat_last", 32'(got.last), 32'(e.last));
      checkOutput("beat_err", 32'(got.err), 32'(e.err));
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (req0_valid && req1_valid) checkOutput("one_ready", 32'(req0_ready & req1_ready), 0);
      if (rsp0_valid || rsp1_valid) checkOutput("valid_onehot", 32'(rsp0_valid & rsp1_valid), 0);
      if (stall_prev) begin
        checkOutput("stall_valid", 32'(stall_port ? rsp1_valid : rsp0_valid), 1);
        checkOutput("stall_beat", stall_port ? 32'({rsp1_data, rsp1_last, rsp1_err})
                                             : 32'({rsp0_data, rsp0_last, rsp0_err}),
                    32'(stall_beat));
      end
      stall_prev = 1'b0;
      if (rsp0_valid) begin
        if (rsp0_ready) scoreBeat(0, {rsp0_data, rsp0_last, rsp0_err});
        else begin
          stall_prev = 1'b1; stall_port = 1'b0; stall_beat = {rsp0_data, rsp0_last, rsp0_err};
        end
      end
      if (rsp1_valid) begin
        if (rsp1_ready) scoreBeat(1, {rsp1_data, rsp1_last, rsp1_err});
        else begin
          stall_prev = 1'b1; stall_port = 1'b1; stall_beat = {rsp1_data, rsp1_last, rsp1_err};
        end
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (n < 200 && (busy || q0.size() != 0 || q1.size() != 0)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_done", 32'({busy, q0.size() != 0, q1.size() != 0}), 0);
    @(posedge clk);
    #1;
  endtask

  // Called one cycle after the grant: address shows now, first beat next cycle.
  task automatic checkLatency(input int port, input logic [3:0] addr);
    @(negedge clk);
    checkOutput("lat_rom_addr", 32'(rom_addr), 32'(addr));
    checkOutput("lat_no_early_valid", 32'(rsp0_valid | rsp1_valid), 0);
    @(negedge clk);
    checkOutput("lat_first_valid", 32'(port == 0 ? rsp0_valid : rsp1_valid), 1);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_flags", 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_last,
                                  rsp1_last, rsp0_err, rsp1_err, busy}), 0);
    checkOutput("rst_data", 32'({rsp0_data, rsp1_data}), 0);
    checkOutput("rst_rom_addr", 32'(rom_addr), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w0, w1, wa, wb;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs();
    @(posedge clk);
    #1 rst = 1'b0;

    // First tie after reset goes to port 0; port 1 follows after one burst.
    grant_log.delete();
    fork
      applyStimulus(0, 4'd0, 4'd0, w0);
      applyStimulus(1, 4'd4, 4'd1, w1);
    join
    waitIdle();
    checkOutput("tie_first", grant_log[0], 0);
    checkOutput("tie_second", grant_log[1], 1);
    checkOutput("tie_loser_wait", w1, 4);

    // Port 0 alone, 4 beats, ready held high.
    applyStimulus(0, 4'd0, 4'd3, w0);
    checkOutput("solo_grant_wait", w0, 1);
    checkLatency(0, 4'd0);
    repeat (3) @(negedge clk);
    checkOutput("busy_at_last", 32'(busy), 1);
    checkOutput("last_beat_flag", 32'(rsp0_last & rsp0_valid), 1);
    @(negedge clk);
    checkOutput("busy_after_last", 32'(busy), 0);
    waitIdle();

    // Backpressure on port 0.
    applyStimulus(0, 4'd2, 4'd2, w0);
    rsp0_ready = 1'b1;
    @(posedge clk); #1 rsp0_ready = 1'b0;
    @(posedge clk); #1 rsp0_ready = 1'b0;
    @(posedge clk); #1 rsp0_ready = 1'b1;
    @(posedge clk); #1 rsp0_ready = 1'b1;
    waitIdle();

    // Address wrap on port 1.
    applyStimulus(1, 4'd15, 4'd1, w1);
    waitIdle();

    // Reset during the second beat of a 4-beat burst.
    applyStimulus(0, 4'd0, 4'd3, w0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkResetOutputs();
    q0.delete();
    @(posedge clk); #1;
    applyStimulus(1, 4'd1, 4'd0, w1);
    checkOutput("post_rst_grant_wait", w1, 1);
    checkLatency(1, 4'd1);
    waitIdle();

    // Port 0 holds valid across two requests while port 1 also requests twice.
    grant_log.delete();
    fork
      begin
        applyStimulus(0, 4'd0, 4'd0, wa);
        applyStimulus(0, 4'd1, 4'd1, wa);
      end
      begin
        applyStimulus(1, 4'd2, 4'd0, wb);
        applyStimulus(1, 4'd3, 4'd2, wb);
      end
    join
    waitIdle();
    checkOutput("alt_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      checkOutput("alt_order", grant_log[i], i % 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

Two-port read arbiter and burst sequencer for the combinational lookup ROM. Each requester issues a start address and beat count over a valid/ready handshake. The block grants ports round-robin and walks the ROM address one beat per cycle. It returns registered data with backpressure to the granted port only. It sits between the ROM instance and its two consumers, so the ROM's single address port is shared without external muxing.

## Interface
- ADDR_WIDTH, 4, ROM address width.
- DATA_WIDTH, 8, ROM data width.
- LEN_WIDTH, 4, burst length field width; beats = len + 1, so 1 to 16 beats.
- ROM_DEPTH, 6, number of populated ROM entries; used only by the range check.

Ports:
- clk  in  1  the only clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- reqN_valid  in  1  port N (N = 0, 1) request valid.
- reqN_ready  out  1  port N request accepted this cycle (grant pulse).
- reqN_addr  in  ADDR_WIDTH  port N burst start address.
- reqN_len  in  LEN_WIDTH  port N beat count minus one.
- rspN_valid  out  1  port N response beat valid.
- rspN_ready  in  1  port N consumer ready.
- rspN_data  out  DATA_WIDTH  response data; the same register drives both ports.
- rspN_last  out  1  final beat of the burst.
- rspN_err  out  1  beat address is out of range (see Configuration).
- rom_addr  out  ADDR_WIDTH  address to the ROM.
- rom_dout  in  DATA_WIDTH  combinational ROM data.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, STREAM, DRAIN.
- IDLE:
  - If any reqN_valid is high, grant one port and pulse its reqN_ready for exactly one cycle.
  - Latch addr into cur_addr, len into remaining, and the owner ID.
  - Go to STREAM.
- Arbitration: round-robin on a one-bit last_grant pointer, updated to the granted port on each grant.
  - On a tie, the port not equal to last_grant wins.
  - last_grant resets to 1, so port 0 wins the first tie.
- STREAM:
  - rom_addr = cur_addr.
  - The output register loads when !rsp_valid_int || rspOwner_ready. On a load:
    - rsp_data <= rom_dout;
    - rsp_last <= (remaining == 0);
    - cur_addr <= cur_addr + 1, wrapping modulo 2^ADDR_WIDTH;
    - remaining <= remaining - 1.
  - When the beat with remaining == 0 loads, go to DRAIN.
- DRAIN: hold the final beat until the owner handshakes it, then go to IDLE. No new grant is issued in DRAIN.
- Response routing:
  - rspN_valid = rsp_valid_int && (owner == N).
  - The non-owner port sees rspN_valid = 0.
  - rsp_data, rsp_last and rsp_err are presented on both ports; they are meaningful only with that port's valid high.
- reqN_valid seen in STREAM or DRAIN gets no ready. The requester holds its request until granted.
- Reset values: reqN_ready 0, rspN_valid 0, rsp_data 0, rsp_last 0, rsp_err 0, rom_addr 0, busy 0, state IDLE, last_grant 1.
- Reset mid-burst drops the burst. The next cycle shows every output at its reset value.

## Timing
- Grant at cycle T. rom_addr presents the start address in cycle T+1. First rspN_valid appears at T+2.
- With ready held high the block sustains one beat per cycle. An L-beat burst finishes its last handshake at T+L+1, and the next grant can occur at T+L+2.
- Ready low holds data, last and valid stable. cur_addr does not advance.
- Ready high with valid high completes a beat. A new beat loads in the same cycle if one remains.
- Simultaneous requests in IDLE: exactly one ready pulses; the other port waits at least one full burst.

## Configuration
- ROM_ARB_RANGE_CHECK_EN defined:
  - A beat whose address is >= ROM_DEPTH loads rsp_data = 0 and rsp_err = 1.
  - In-range beats load rsp_err = 0.
  - The burst continues regardless of errors.
- Not defined: rsp_err is tied to 0 and rom_dout passes through unmodified for every address.

## Test plan
- Port 0 only, addr 0, len 3, ready high -> ready pulse at T; data A1, B2, C3, D4 on cycles T+2..T+5; last only on D4; busy falls after the final beat.
- Both ports valid in the same cycle, port 1 addr 4, len 1 -> port 0 wins the first tie; port 1 is granted next and receives E5, F6.
- Port 0, addr 2, len 2, rsp0_ready toggled 1,0,0,1,1 -> C3 held stable across the stalls; D4 and E5 follow in order; no beat lost or duplicated.
- Port 1, addr 15, len 1 -> the address wraps to 0. The second beat reads A1.
  - With ROM_ARB_RANGE_CHECK_EN: first beat data 0, err 1; second beat err 0.
  - Without it: err stays 0 on both beats.
- Assert rst during beat 2 of a 4-beat burst -> next cycle all outputs are 0 and state is IDLE; a new port 1 request is then granted with normal latency.
- Port 0 holds valid continuously while port 1 requests -> grants alternate 0, 1, 0, 1.
